btb_redirect_unit: RTL and testbench

// Fetch-side companion to the gshare direction predictor. Holds a direct-mapped branch target buffer (BTB).
// At fetch it combines a BTB hit with the gshare taken bit to form a predicted next PC.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/btb_redirect_unit_if.sv | 29 ++
 rtl/bp_inflight_fifo.sv | 69 ++++++
 rtl/btb_redirect_unit.sv | 147 ++++++++++++++
 tb/tb_btb_redirect_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types, widths and PC helpers for the BTB redirect unit.
package bp_pkg;

  localparam int DEF_PC_W        = 14;
  localparam int DEF_BTB_ENTRIES = 64;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int IDX_W           = $clog2(DEF_BTB_ENTRIES);
  localparam int TAG_W           = DEF_PC_W - IDX_W - 2;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [DEF_PC_W-1:0] target;
  } btb_entry_t;

  typedef struct packed {
    logic [DEF_PC_W-1:0] pc;
    logic                taken;
    logic [DEF_PC_W-1:0] target;
  } inflight_t;

  // Sequential successor of a 4-byte instruction; wraps modulo 2^PC_W.
  function automatic logic [DEF_PC_W-1:0] next_seq_pc(input logic [DEF_PC_W-1:0] pc);
    return pc + DEF_PC_W'(3'd4);
  endfunction

  // BTB set index: word address bits just above the byte offset.
  function automatic logic [IDX_W-1:0] pc_index(input logic [DEF_PC_W-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  // BTB tag: everything above the index.
  function automatic logic [TAG_W-1:0] pc_tag(input logic [DEF_PC_W-1:0] pc);
    return pc[DEF_PC_W-1:IDX_W+2];
  endfunction

endpackage

// File: rtl/btb_redirect_unit_if.sv
// Fetch-side lookup and EX-side resolve signals of the BTB redirect unit.
interface btb_redirect_unit_if #(
  parameter int PC_W = bp_pkg::DEF_PC_W
);
  logic [PC_W-1:0] pc_f;
  logic            branch_en_f;
  logic            bp_taken;
  logic            pred_valid_f;
  logic            pred_taken_f;
  logic [PC_W-1:0] pred_target_f;
  logic            fifo_full;
  logic [PC_W-1:0] pc_ex;
  logic            branch_en_ex;
  logic            branch_result;
  logic [PC_W-1:0] target_ex;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic            err;

  modport master (
    output pc_f, branch_en_f, bp_taken, pc_ex, branch_en_ex, branch_result, target_ex,
    input  pred_valid_f, pred_taken_f, pred_target_f, fifo_full, mispredict, redirect_pc, err
  );

  modport slave (
    input  pc_f, branch_en_f, bp_taken, pc_ex, branch_en_ex, branch_result, target_ex,
    output pred_valid_f, pred_taken_f, pred_target_f, fifo_full, mispredict, redirect_pc, err
  );
endinterface

// File: rtl/bp_inflight_fifo.sv
// Synchronous FIFO of in-flight predictions; flush wins over push, pop-then-push at full is accepted.
module bp_inflight_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int L_PTR_W = $clog2(DEPTH);
  localparam int L_CNT_W = L_PTR_W + 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [L_PTR_W-1:0] r_wr_ptr;
  logic [L_PTR_W-1:0] r_rd_ptr;
  logic [L_CNT_W-1:0] r_count;
  logic [L_CNT_W-1:0] w_count_nxt;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == L_CNT_W'(DEPTH));
  assign o_empty   = (r_count == {L_CNT_W{1'b0}});
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + L_CNT_W'(1'b1);
      2'b01:   w_count_nxt = r_count - L_CNT_W'(1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, pointers and count; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + L_PTR_W'(1'b1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_W'(1'b1);
      end
      r_count <= w_count_nxt;
    end
  end
endmodule

// File: rtl/btb_redirect_unit.sv
// Direct-mapped BTB lookup at fetch, in-flight tracking, and mispredict/redirect at EX.
module btb_redirect_unit
  import bp_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int BTB_ENTRIES = DEF_BTB_ENTRIES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic                clk,
  input logic                rst,
  btb_redirect_unit_if.slave bus
);
  localparam int L_CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int L_FIFO_W = $bits(inflight_t);

  btb_entry_t          r_btb [BTB_ENTRIES];
  logic                r_lookup_v;
  logic [PC_W-1:0]     r_lookup_pc;
  btb_entry_t          r_rd_entry;
  logic                r_mispredict;
  logic [PC_W-1:0]     r_redirect_pc;
  logic                r_err;

  logic [L_CNT_W-1:0]  w_count;
  logic                w_full;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [L_FIFO_W-1:0] w_fifo_head_raw;
  inflight_t           w_fifo_head;
  inflight_t           w_push_data;
  logic                w_lookup_acc;
  logic                w_drop;
  logic                w_pred_taken;
  logic [PC_W-1:0]     w_pred_target;
  logic                w_head_taken;
  logic [PC_W-1:0]     w_head_target;
  logic                w_mis;
  logic [PC_W-1:0]     w_redirect;
  logic                w_push_err;
  logic                w_pop_err;

  assign w_full       = (w_count == L_CNT_W'(FIFO_DEPTH));
  assign w_lookup_acc = bus.branch_en_f & ~w_full;
  assign w_drop       = bus.branch_en_f & w_full;
  assign w_fifo_head  = w_fifo_head_raw;
  assign w_push_data  = '{pc: r_lookup_pc, taken: w_pred_taken, target: w_pred_target};
  // A push is only an error when it is neither wrong-path (flushed) nor paired with a pop.
  assign w_push_err   = r_lookup_v & ~r_mispredict & w_fifo_full & ~(bus.branch_en_ex & ~w_fifo_empty);
  assign w_pop_err    = bus.branch_en_ex & w_fifo_empty;

  bp_inflight_fifo #(
    .DATA_W (L_FIFO_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_lookup_v),
    .i_push_data (w_push_data),
    .i_pop       (bus.branch_en_ex),
    .i_flush     (r_mispredict),
    .o_head      (w_fifo_head_raw),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_count)
  );

  // BTB array: only taken resolutions allocate or overwrite an entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i] <= '0;
      end
    end else if (bus.branch_en_ex && bus.branch_result) begin
      r_btb[pc_index(bus.pc_ex)] <= '{valid: 1'b1, tag: pc_tag(bus.pc_ex), target: bus.target_ex};
    end
  end

  // Lookup stage: capture the entry itself so a same-cycle update is not visible (read-before-write).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lookup_v  <= 1'b0;
      r_lookup_pc <= '0;
      r_rd_entry  <= '0;
    end else begin
      r_lookup_v <= w_lookup_acc;
      if (w_lookup_acc) begin
        r_lookup_pc <= bus.pc_f;
        r_rd_entry  <= r_btb[pc_index(bus.pc_f)];
      end
    end
  end

  // Prediction: a hit lets the gshare bit through; a miss predicts not-taken with a zero target.
  always_comb begin
    w_pred_taken  = 1'b0;
    w_pred_target = '0;
    if (r_lookup_v && r_rd_entry.valid && (r_rd_entry.tag == pc_tag(r_lookup_pc))) begin
      w_pred_taken  = bus.bp_taken;
      w_pred_target = r_rd_entry.target;
    end else begin
      w_pred_taken  = 1'b0;
      w_pred_target = '0;
    end
  end

  // Resolve: compare the oldest prediction (or a not-taken stand-in when empty) with the outcome.
  always_comb begin
    w_head_taken  = 1'b0;
    w_head_target = '0;
    w_redirect    = '0;
    if (!w_fifo_empty) begin
      w_head_taken  = w_fifo_head.taken;
      w_head_target = w_fifo_head.target;
    end else begin
      w_head_taken  = 1'b0;
      w_head_target = '0;
    end
    w_mis = (w_head_taken != bus.branch_result) |
            (bus.branch_result & w_head_taken & (w_head_target != bus.target_ex));
    if (bus.branch_result) begin
      w_redirect = bus.target_ex;
    end else begin
      w_redirect = next_seq_pc(bus.pc_ex);
    end
  end

  // Registered mispredict pulse, redirect target and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      r_err         <= 1'b0;
    end else begin
      r_mispredict  <= bus.branch_en_ex & w_mis;
      r_redirect_pc <= (bus.branch_en_ex & w_mis) ? w_redirect : '0;
      r_err         <= r_err | w_drop | w_push_err | w_pop_err;
    end
  end

  assign bus.pred_valid_f  = r_lookup_v;
  assign bus.pred_taken_f  = w_pred_taken;
  assign bus.pred_target_f = w_pred_target;
  assign bus.fifo_full     = w_full;
  assign bus.mispredict    = r_mispredict;
  assign bus.redirect_pc   = r_redirect_pc;
  assign bus.err           = r_err;
endmodule

// File: tb/tb_btb_redirect_unit.sv
// Directed bench for btb_redirect_unit: queue/array reference model checked every cycle, plus literal checks.
module tb_btb_redirect_unit;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  btb_redirect_unit_if #(.PC_W(14)) bus ();

  btb_redirect_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int pc;
    bit taken;
    int target;
  } pred_t;

  pred_t m_q[$];
  bit    m_bv [64];
  int    m_bg [64];
  int    m_bt [64];
  bit    m_lk_v;
  int    m_lk_pc;
  bit    m_lk_ev;
  int    m_lk_eg;
  int    m_lk_et;
  bit    m_mis;
  int    m_redir;
  bit    m_err;

  function automatic bit model_hit();
    return m_lk_v && m_lk_ev && (m_lk_eg == (m_lk_pc >> 8));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      for (int i = 0; i < 64; i++) begin
        m_bv[i] = 1'b0; m_bg[i] = 0; m_bt[i] = 0;
      end
      m_lk_v = 1'b0; m_lk_pc = 0; m_lk_ev = 1'b0; m_lk_eg = 0; m_lk_et = 0;
      m_mis = 1'b0; m_redir = 0; m_err = 1'b0;
    end else begin : model_step
      bit    flush;
      bit    full;
      bit    hit;
      bit    n_mis;
      bit    n_lk_v;
      int    n_redir;
      int    idx;
      pred_t p;
      pred_t h;
      flush   = m_mis;
      full    = (m_q.size() == 4);
      hit     = model_hit();
      p.pc     = m_lk_pc;
      p.taken  = hit && bus.bp_taken;
      p.target = hit ? m_lk_et : 0;
      n_mis   = 1'b0;
      n_redir = 0;
      if (bus.branch_en_ex) begin
        if (m_q.size() > 0) h = m_q[0];
        else begin
          h.pc = 0; h.taken = 1'b0; h.target = 0;
          m_err = 1'b1;
        end
        n_mis = (h.taken != bus.branch_result) ||
                (bus.branch_result && h.taken && (h.target != int'(bus.target_ex)));
        if (n_mis) n_redir = bus.branch_result ? int'(bus.target_ex) : (int'(bus.pc_ex) + 4) % 16384;
      end
      n_lk_v = 1'b0;
      if (bus.branch_en_f) begin
        if (full) m_err = 1'b1;
        else begin
          n_lk_v  = 1'b1;
          m_lk_pc = int'(bus.pc_f);
          idx     = (m_lk_pc >> 2) % 64;
          m_lk_ev = m_bv[idx]; m_lk_eg = m_bg[idx]; m_lk_et = m_bt[idx];
        end
      end
      if (bus.branch_en_ex && bus.branch_result) begin
        idx = (int'(bus.pc_ex) >> 2) % 64;
        m_bv[idx] = 1'b1; m_bg[idx] = int'(bus.pc_ex) >> 8; m_bt[idx] = int'(bus.target_ex);
      end
      if (flush) m_q.delete();
      else begin
        if (bus.branch_en_ex && (m_q.size() > 0)) void'(m_q.pop_front());
        if (m_lk_v) begin
          if (m_q.size() < 4) m_q.push_back(p);
          else m_err = 1'b1;
        end
      end
      m_lk_v  = n_lk_v;
      m_mis   = n_mis;
      m_redir = n_redir;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin : cmp
      bit h;
      h = model_hit();
      chk("pred_valid_f", bus.pred_valid_f, m_lk_v);
      chk("pred_taken_f", bus.pred_taken_f, h && bus.bp_taken);
      if (m_lk_v) chk("pred_target_f", bus.pred_target_f, h ? m_lk_et : 0);
      chk("fifo_full", bus.fifo_full, m_q.size() == 4);
      chk("mispredict", bus.mispredict, m_mis);
      if (m_mis) chk("redirect_pc", bus.redirect_pc, m_redir);
      chk("err", bus.err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit ef, input int pf, input bit bt,
                       input bit ee, input int pe, input bit br, input int te);
    @(posedge clk); #1;
    bus.branch_en_f   = ef;
    bus.pc_f          = 14'(pf);
    bus.bp_taken      = bt;
    bus.branch_en_ex  = ee;
    bus.pc_ex         = 14'(pe);
    bus.branch_result = br;
    bus.target_ex     = 14'(te);
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    @(negedge clk);
  endtask

  task automatic fetch(input int pc, input bit bpt);
    drive(1'b1, pc, 1'b0, 1'b0, 0, 1'b0, 0);
    drive(1'b0, 0, bpt, 1'b0, 0, 1'b0, 0);
    @(negedge clk);
  endtask

  task automatic resolve(input int pc, input bit res, input int tgt);
    drive(1'b0, 0, 1'b0, 1'b1, pc, res, tgt);
    drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.branch_en_f = 1'b0; bus.pc_f = '0; bus.bp_taken = 1'b0;
    bus.branch_en_ex = 1'b0; bus.pc_ex = '0; bus.branch_result = 1'b0; bus.target_ex = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("lit_rst_pred_valid", bus.pred_valid_f, 1'b0);
    chk("lit_rst_mispredict", bus.mispredict, 1'b0);
    chk("lit_rst_err", bus.err, 1'b0);
    chk("lit_rst_full", bus.fifo_full, 1'b0);
    @(posedge clk); #1 rst = 1'b1;

    // Cold miss, then train and hit.
    fetch(32'h0040, 1'b1);
    chk("lit_cold_valid", bus.pred_valid_f, 1'b1);
    chk("lit_cold_taken", bus.pred_taken_f, 1'b0);
    resolve(32'h0040, 1'b1, 32'h0100);
    chk("lit_train_mis", bus.mispredict, 1'b1);
    chk("lit_train_redir", bus.redirect_pc, 32'h0100);
    fetch(32'h0040, 1'b1);
    chk("lit_hit_taken", bus.pred_taken_f, 1'b1);
    chk("lit_hit_target", bus.pred_target_f, 32'h0100);
    resolve(32'h0040, 1'b1, 32'h0100);
    chk("lit_correct_mis", bus.mispredict, 1'b0);

    // Alias on index 16 with a different tag.
    fetch(32'h0140, 1'b1);
    chk("lit_alias_miss", bus.pred_taken_f, 1'b0);
    resolve(32'h0140, 1'b1, 32'h0200);
    fetch(32'h0040, 1'b1);
    chk("lit_evicted_miss", bus.pred_taken_f, 1'b0);
    resolve(32'h0040, 1'b1, 32'h0100);

    // Wrong target.
    fetch(32'h0040, 1'b1);
    resolve(32'h0040, 1'b1, 32'h0180);
    chk("lit_wrongtgt_mis", bus.mispredict, 1'b1);
    chk("lit_wrongtgt_redir", bus.redirect_pc, 32'h0180);

    // Hit with gshare not-taken, resolved not-taken: no mispredict.
    fetch(32'h0040, 1'b0);
    chk("lit_hit_nt_taken", bus.pred_taken_f, 1'b0);
    resolve(32'h0040, 1'b0, 32'h0000);
    chk("lit_nt_correct", bus.mispredict, 1'b0);

    // Not-taken at the top of the address space wraps to 0.
    fetch(32'h3FFC, 1'b1);
    resolve(32'h3FFC, 1'b1, 32'h0800);
    fetch(32'h3FFC, 1'b1);
    chk("lit_top_target", bus.pred_target_f, 32'h0800);
    resolve(32'h3FFC, 1'b0, 32'h1234);
    chk("lit_wrap_mis", bus.mispredict, 1'b1);
    chk("lit_wrap_redir", bus.redirect_pc, 32'h0000);

    // Lookup and update to the same index in one cycle: lookup sees the old entry.
    fetch(32'h0140, 1'b1);
    drive(1'b1, 32'h0040, 1'b0, 1'b1, 32'h0140, 1'b1, 32'h02C0);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0);
    @(negedge clk);
    chk("lit_rbw_taken", bus.pred_taken_f, 1'b1);
    chk("lit_rbw_target", bus.pred_target_f, 32'h0180);
    chk("lit_rbw_redir", bus.redirect_pc, 32'h02C0);

    // Pop from the (flushed) empty FIFO.
    chk("lit_pre_err", bus.err, 1'b0);
    resolve(32'h0040, 1'b1, 32'h0300);
    chk("lit_empty_mis", bus.mispredict, 1'b1);
    chk("lit_empty_err", bus.err, 1'b1);

    // Reset mid-operation discards BTB and in-flight state.
    fetch(32'h0040, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    bus.bp_taken = 1'b0;
    @(negedge clk);
    chk("lit_midrst_err", bus.err, 1'b0);
    chk("lit_midrst_valid", bus.pred_valid_f, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    fetch(32'h0040, 1'b1);
    chk("lit_after_rst_miss", bus.pred_taken_f, 1'b0);

    // Fill to four, drop a fifth, then flush on a mispredict.
    fetch(32'h0080, 1'b0);
    fetch(32'h00C0, 1'b0);
    fetch(32'h0100, 1'b0);
    idle();
    chk("lit_full", bus.fifo_full, 1'b1);
    fetch(32'h0140, 1'b1);
    chk("lit_drop_valid", bus.pred_valid_f, 1'b0);
    chk("lit_drop_err", bus.err, 1'b1);
    resolve(32'h0040, 1'b1, 32'h0100);
    chk("lit_flush_mis", bus.mispredict, 1'b1);
    chk("lit_flush_notfull", bus.fifo_full, 1'b0);

    // Refill from empty: full only after the fourth push.
    fetch(32'h0040, 1'b1);
    chk("lit_refill_hit", bus.pred_taken_f, 1'b1);
    fetch(32'h0040, 1'b1);
    fetch(32'h0040, 1'b1);
    idle();
    chk("lit_three_notfull", bus.fifo_full, 1'b0);
    fetch(32'h0040, 1'b1);
    idle();
    chk("lit_four_full", bus.fifo_full, 1'b1);

    // Back-to-back resolutions; the last one mispredicts not-taken.
    drive(1'b0, 0, 1'b0, 1'b1, 32'h0040, 1'b1, 32'h0100);
    drive(1'b0, 0, 1'b0, 1'b1, 32'h0040, 1'b1, 32'h0100);
    drive(1'b0, 0, 1'b0, 1'b1, 32'h0040, 1'b1, 32'h0100);
    drive(1'b0, 0, 1'b0, 1'b1, 32'h0040, 1'b0, 32'h0000);
    idle();
    chk("lit_b2b_mis", bus.mispredict, 1'b1);
    chk("lit_b2b_redir", bus.redirect_pc, 32'h0044);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
